// File: rtl/fc_layer_stream_gen.sv
// Purpose : fully-connected layer y[m] = act(sat(sum_n W[m][n]*x[n] >>> FRAC)), P MAC lanes, runtime-loadable weights.
// Latency : N input beats, then per group of P rows N+2 compute cycles followed by P output beats.
// Backpress: all three streams are valid/ready; gaps on w/input stall the counters, output_ready low freezes output_data.
//
// Ports:
//   clk, reset                        rising-edge clock, asynchronous active-low reset
//   w_valid/w_ready/w_data            weight stream, row-major (m*N+n), accepted only in LOAD_W
//   input_valid/input_ready/input_data x[0..N-1] stream, accepted only in LOAD_X once weights are loaded
//   output_valid/output_ready/output_data y[0..M-1] stream
module fc_layer_stream_gen #(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int T    = 16,
    parameter int P    = 2,
    parameter int FRAC = 0,
    parameter int RELU = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic signed [T-1:0] w_data,
    input  logic                input_valid,
    output logic                input_ready,
    input  logic signed [T-1:0] input_data,
    output logic                output_valid,
    input  logic                output_ready,
    output logic signed [T-1:0] output_data
);

    localparam int G     = M / P;
    localparam int DEPTH = G * N;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW    = $clog2(N);
    localparam int CW    = $clog2(N + 2);
    localparam int LW    = (P > 1) ? $clog2(P) : 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int ACCW  = 2 * T + $clog2(N);

    localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-T+1){1'b0}}, {(T-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-T+1){1'b1}}, {(T-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_X,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t                 r_state;
    logic                   r_wloaded;
    logic [XW-1:0]          r_wn;
    logic [LW-1:0]          r_wlane;
    logic [AW-1:0]          r_wbase;
    logic [XW-1:0]          r_xn;
    logic signed [T-1:0]    r_xbuf [N];
    logic [CW-1:0]          r_cc;
    logic [GW-1:0]          r_g;
    logic [AW-1:0]          r_gbase;
    logic signed [ACCW-1:0] r_acc  [P];
    logic signed [T-1:0]    r_res  [P];
    logic [LW-1:0]          r_olane;

    // Lane-banked weight store: no reset, contents are meaningless until a full load.
    logic signed [T-1:0]    r_wmem [P][DEPTH];
    logic signed [T-1:0]    r_wrd  [P];
    logic signed [T-1:0]    r_xrd;

    logic                   w_we;
    logic [AW-1:0]          w_waddr;
    logic [AW-1:0]          w_raddr;
    logic [XW-1:0]          w_xidx;
    logic                   w_wlast;
    logic signed [2*T-1:0]  w_prod [P];
    logic signed [ACCW-1:0] w_sh   [P];
    logic signed [T-1:0]    w_res  [P];

    assign w_ready      = (r_state == S_LOAD_W);
    assign input_ready  = (r_state == S_LOAD_X);
    assign output_valid = (r_state == S_OUTPUT);
    // Lane results are shifted down on each handshake, so slot 0 is always the word on the bus.
    assign output_data  = r_res[0];

    assign w_we    = (r_state == S_LOAD_W) && w_valid;
    assign w_waddr = r_wbase + AW'(r_wn);
    assign w_wlast = (r_wn == XW'(N-1)) && (r_wlane == LW'(P-1)) && (r_wbase == AW'(DEPTH-N));
    // Read address runs past N-1 during the drain cycles; those reads are never consumed.
    assign w_raddr = r_gbase + AW'(r_cc);
    assign w_xidx  = r_cc[XW-1:0];

    always_ff @(posedge clk) begin
        for (int p = 0; p < P; p++) begin
            if (w_we && (r_wlane == LW'(p))) begin
                r_wmem[p][w_waddr] <= w_data;
            end
            r_wrd[p] <= r_wmem[p][w_raddr];
        end
        r_xrd <= r_xbuf[w_xidx];
    end

    always_comb begin
        for (int p = 0; p < P; p++) begin
            w_prod[p] = r_wrd[p] * r_xrd;
            w_sh[p]   = r_acc[p] >>> FRAC;
            if (w_sh[p] > SMAX) begin
                w_res[p] = SMAX[T-1:0];
            end else if (w_sh[p] < SMIN) begin
                w_res[p] = SMIN[T-1:0];
            end else begin
                w_res[p] = w_sh[p][T-1:0];
            end
            if ((RELU != 0) && w_res[p][T-1]) begin
                w_res[p] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_wloaded <= 1'b0;
            r_wn      <= '0;
            r_wlane   <= '0;
            r_wbase   <= '0;
            r_xn      <= '0;
            r_cc      <= '0;
            r_g       <= '0;
            r_gbase   <= '0;
            r_olane   <= '0;
            for (int i = 0; i < N; i++) r_xbuf[i] <= '0;
            for (int p = 0; p < P; p++) begin
                r_acc[p] <= '0;
                r_res[p] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_state <= S_LOAD_W;
                        r_wn    <= '0;
                        r_wlane <= '0;
                        r_wbase <= '0;
                    end else if (r_wloaded && input_valid) begin
                        r_state <= S_LOAD_X;
                        r_xn    <= '0;
                    end
                end

                S_LOAD_W: begin
                    if (w_valid) begin
                        if (r_wn == XW'(N-1)) begin
                            r_wn <= '0;
                            if (r_wlane == LW'(P-1)) begin
                                r_wlane <= '0;
                                r_wbase <= r_wbase + AW'(N);
                            end else begin
                                r_wlane <= r_wlane + 1'b1;
                            end
                        end else begin
                            r_wn <= r_wn + 1'b1;
                        end
                        if (w_wlast) begin
                            r_wloaded <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end

                S_LOAD_X: begin
                    if (input_valid) begin
                        r_xbuf[r_xn] <= input_data;
                        if (r_xn == XW'(N-1)) begin
                            r_state <= S_COMPUTE;
                            r_cc    <= '0;
                            r_g     <= '0;
                            r_gbase <= '0;
                            for (int p = 0; p < P; p++) r_acc[p] <= '0;
                        end else begin
                            r_xn <= r_xn + 1'b1;
                        end
                    end
                end

                S_COMPUTE: begin
                    // cycle 0 issues read n=0; cycles 1..N accumulate; cycle N+1 latches results.
                    r_cc <= r_cc + 1'b1;
                    if ((r_cc >= CW'(1)) && (r_cc <= CW'(N))) begin
                        for (int p = 0; p < P; p++) begin
                            r_acc[p] <= r_acc[p] + {{(ACCW-2*T){w_prod[p][2*T-1]}}, w_prod[p]};
                        end
                    end
                    if (r_cc == CW'(N+1)) begin
                        for (int p = 0; p < P; p++) r_res[p] <= w_res[p];
                        r_olane <= '0;
                        r_state <= S_OUTPUT;
                    end
                end

                S_OUTPUT: begin
                    if (output_ready) begin
                        for (int p = 0; p < P - 1; p++) r_res[p] <= r_res[p+1];
                        r_res[P-1] <= '0;
                        if (r_olane == LW'(P-1)) begin
                            if (r_g == GW'(G-1)) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_g     <= r_g + 1'b1;
                                r_gbase <= r_gbase + AW'(N);
                                r_cc    <= '0;
                                for (int p = 0; p < P; p++) r_acc[p] <= '0;
                                r_state <= S_COMPUTE;
                            end
                        end else begin
                            r_olane <= r_olane + 1'b1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_stream_gen.sv
// Three instances share one stimulus stream: d0 ReLU/FRAC=0, d1 identity/FRAC=0, d2 identity/FRAC=4.
module tb_fc_layer_stream_gen;

    localparam int M = 4;
    localparam int N = 3;
    localparam int T = 16;
    localparam int P = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                w_valid;
    logic signed [T-1:0] w_data;
    logic                input_valid;
    logic signed [T-1:0] input_data;
    logic                output_ready;
    logic                w_ready      [3];
    logic                input_ready  [3];
    logic                output_valid [3];
    logic signed [T-1:0] output_data  [3];

    fc_layer_stream_gen #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .RELU(1)) u_d0 (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready[0]), .w_data(w_data),
        .input_valid(input_valid), .input_ready(input_ready[0]), .input_data(input_data),
        .output_valid(output_valid[0]), .output_ready(output_ready), .output_data(output_data[0])
    );
    fc_layer_stream_gen #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .RELU(0)) u_d1 (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready[1]), .w_data(w_data),
        .input_valid(input_valid), .input_ready(input_ready[1]), .input_data(input_data),
        .output_valid(output_valid[1]), .output_ready(output_ready), .output_data(output_data[1])
    );
    fc_layer_stream_gen #(.M(M), .N(N), .T(T), .P(P), .FRAC(4), .RELU(0)) u_d2 (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready[2]), .w_data(w_data),
        .input_valid(input_valid), .input_ready(input_ready[2]), .input_data(input_data),
        .output_valid(output_valid[2]), .output_ready(output_ready), .output_data(output_data[2])
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int wbuf [12];
    int xbuf [3];
    int e0 [4];
    int e1 [4];
    int e2 [4];
    logic ir_seen;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w();
        for (int k = 0; k < 12; k++) begin
            int c;
            w_valid = 1'b1;
            w_data  = T'(wbuf[k]);
            c = 0;
            while (!w_ready[0] && c < 50) begin
                ir_seen = ir_seen | input_ready[0];
                tick();
                c++;
            end
            if (c >= 50) chk("w_ready_timeout", 0, 1);
            ir_seen = ir_seen | input_ready[0];
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic send_x(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            int c;
            input_valid = 1'b1;
            input_data  = T'(xbuf[k]);
            c = 0;
            while (!input_ready[0] && c < 50) begin
                tick();
                c++;
            end
            if (c >= 50) chk("input_ready_timeout", 0, 1);
            tick();
        end
        input_valid = 1'b0;
    endtask

    task automatic recv(input string tag);
        output_ready = 1'b1;
        for (int m = 0; m < M; m++) begin
            int c;
            c = 0;
            while (!output_valid[0] && c < 50) begin
                tick();
                c++;
            end
            if (c >= 50) chk($sformatf("%s_valid_timeout_y%0d", tag, m), 0, 1);
            chk($sformatf("%s_d0_y%0d", tag, m), output_data[0], e0[m]);
            chk($sformatf("%s_d1_y%0d", tag, m), output_data[1], e1[m]);
            chk($sformatf("%s_d2_y%0d", tag, m), output_data[2], e2[m]);
            tick();
        end
    endtask

    initial begin
        reset        = 1'b1;
        w_valid      = 1'b0;
        w_data       = '0;
        input_valid  = 1'b1;
        input_data   = 16'sd1;
        output_ready = 1'b0;
        ir_seen      = 1'b0;

        // Reset state
        #2 reset = 1'b0;
        tick();
        tick();
        chk("rst_w_ready", w_ready[0], 0);
        chk("rst_input_ready", input_ready[0], 0);
        chk("rst_output_valid", output_valid[0], 0);
        chk("rst_output_data", output_data[0], 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // No weights: input_ready must stay low despite input_valid.
        for (int i = 0; i < 6; i++) begin
            ir_seen = ir_seen | input_ready[0];
            tick();
        end

        // Vector 1: W=A, x=[1,1,1]
        wbuf = '{1, 2, 3, -1, 0, 0, 0, 4, 0, 2, 2, 2};
        load_w();
        chk("input_ready_before_load", ir_seen, 0);
        xbuf = '{1, 1, 1};
        send_x(3);
        e0 = '{6, 0, 4, 6};
        e1 = '{6, -1, 4, 6};
        e2 = '{0, -1, 0, 0};
        recv("v1");

        // Vector 2: x=[5,-2,3], first word stalled 5 cycles
        xbuf = '{5, -2, 3};
        output_ready = 1'b0;
        send_x(3);
        begin
            int c;
            c = 0;
            while (!output_valid[0] && c < 50) begin
                tick();
                c++;
            end
            if (c >= 50) chk("stall_valid_timeout", 0, 1);
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_valid_c%0d", i), output_valid[1], 1);
            chk($sformatf("stall_data_c%0d", i), output_data[1], 10);
            tick();
        end
        e0 = '{10, 0, 0, 12};
        e1 = '{10, -5, -8, 12};
        e2 = '{0, -1, -1, 0};
        recv("v2");

        // Saturation, positive then negative
        wbuf = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        load_w();
        xbuf = '{32767, 32767, 32767};
        send_x(3);
        e0 = '{32767, 32767, 32767, 32767};
        e1 = '{32767, 32767, 32767, 32767};
        e2 = '{32767, 32767, 32767, 32767};
        recv("satp");
        xbuf = '{-32768, -32768, -32768};
        send_x(3);
        e0 = '{0, 0, 0, 0};
        e1 = '{-32768, -32768, -32768, -32768};
        e2 = '{-32768, -32768, -32768, -32768};
        recv("satn");

        // Fractional shift
        wbuf = '{16, 16, 16, -1, 0, 0, 0, 4, 0, 2, 2, 2};
        load_w();
        xbuf = '{1, 2, -4};
        send_x(3);
        e0 = '{0, 0, 8, 0};
        e1 = '{-16, -1, 8, -2};
        e2 = '{-1, -1, 0, -1};
        recv("frac_a");
        xbuf = '{1, 2, -3};
        send_x(3);
        e0 = '{0, 0, 8, 0};
        e1 = '{0, -1, 8, 0};
        e2 = '{0, -1, 0, 0};
        recv("frac_b");

        // Reset after 2 of 3 inputs
        xbuf = '{1, 2, -4};
        send_x(2);
        reset = 1'b0;
        #1;
        chk("mid_rst_input_ready", input_ready[0], 0);
        chk("mid_rst_output_valid", output_valid[0], 0);
        chk("mid_rst_output_data", output_data[0], 0);
        chk("mid_rst_w_ready", w_ready[0], 0);
        tick();
        reset = 1'b1;
        ir_seen = 1'b0;
        input_valid = 1'b1;
        input_data  = 16'sd1;
        for (int i = 0; i < 6; i++) begin
            ir_seen = ir_seen | input_ready[0];
            tick();
        end
        wbuf = '{1, 2, 3, -1, 0, 0, 0, 4, 0, 2, 2, 2};
        load_w();
        chk("input_ready_before_reload", ir_seen, 0);
        xbuf = '{1, 1, 1};
        send_x(3);
        e0 = '{6, 0, 4, 6};
        e1 = '{6, -1, 4, 6};
        e2 = '{0, -1, 0, 0};
        recv("post_rst");

        // w_valid and input_valid together in IDLE: weight load wins
        input_valid = 1'b1;
        input_data  = 16'sd3;
        w_valid     = 1'b1;
        w_data      = 16'sd1;
        tick();
        chk("prio_w_ready", w_ready[0], 1);
        chk("prio_input_ready", input_ready[0], 0);
        wbuf = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
        load_w();
        xbuf = '{3, -4, 7};
        send_x(3);
        e0 = '{3, 0, 7, 6};
        e1 = '{3, -4, 7, 6};
        e2 = '{0, -1, 0, 0};
        recv("reload");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
